// File: rtl/seq_pkg.sv
// Shared types and defaults for the serial sequence transmitter and its 1001 detector.
package seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAR   = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam int SEQ_PAT_W = 4;
  localparam int SEQ_CNT_W = 8;
  localparam int SEQ_GAP_W = 4;

  localparam logic [3:0] SEQ_DEFAULT_PAT = 4'b1001;

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, MSB-first shift register; the MSB is the next serial bit.
module seq_piso #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] d,
  output logic             msb
);

  logic [PAT_W-1:0] q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {q[PAT_W-2:0], 1'b0};
    end
  end

  assign msb = q[PAT_W-1];

endmodule

// File: rtl/sequence_transmitter.sv
// Bit-serial pattern generator with repeat count and idle gaps.
// Define SEQ_TX_PARITY_EN to append an even-parity bit after every pattern.
//
// state   | meaning
// S_IDLE  | waiting for start, ready=1
// S_SHIFT | shifting pattern bits out MSB first
// S_PAR   | emitting the even-parity bit (parity build only)
// S_GAP   | idle cycles between repetitions
module sequence_transmitter
  import seq_pkg::*;
#(
  parameter int PAT_W = SEQ_PAT_W,
  parameter int CNT_W = SEQ_CNT_W,
  parameter int GAP_W = SEQ_GAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [CNT_W-1:0] rpt,
  input  logic [GAP_W-1:0] gap,
  output logic             ready,
  output logic             busy,
  output logic             dout,
  output logic             dvalid,
  output logic             frame,
  output logic             done
);

`ifdef SEQ_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int BC_W = $clog2(PAT_W);

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic [CNT_W-1:0] rpt_cnt;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;
  logic [BC_W-1:0]  bit_cnt;

  logic             accept;
  logic             bit_last;
  logic             rep_end;
  logic             rep_more;
  logic             reload;
  logic             piso_load;
  logic             piso_shift;
  logic [PAT_W-1:0] piso_src;
  logic             piso_msb;

  assign ready      = (state == S_IDLE);
  assign accept     = ready && start;
  assign bit_last   = (bit_cnt == BC_W'(PAT_W - 1));
  assign rep_end    = (state == S_SHIFT && bit_last && !PAR_EN) || (state == S_PAR);
  assign rep_more   = (rpt_cnt > CNT_W'(1));
  // Restart the pattern either back-to-back or on the last gap cycle.
  assign reload     = (rep_end && rep_more && gap_q == '0) ||
                      (state == S_GAP && gap_cnt == GAP_W'(1));
  assign piso_load  = accept || reload;
  assign piso_shift = (state == S_SHIFT) && !bit_last;
  assign piso_src   = accept ? pat_in : pat_q;

  // The first bit goes straight to dout, so the PISO holds only the remaining bits.
  seq_piso #(.PAT_W(PAT_W)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (piso_load),
    .shift (piso_shift),
    .d     ({piso_src[PAT_W-2:0], 1'b0}),
    .msb   (piso_msb)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      pat_q   <= '0;
      rpt_cnt <= '0;
      gap_q   <= '0;
      gap_cnt <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      dout    <= 1'b0;
      dvalid  <= 1'b0;
      frame   <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pat_q   <= pat_in;
            rpt_cnt <= (rpt == '0) ? CNT_W'(1) : rpt;
            gap_q   <= gap;
            bit_cnt <= '0;
            state   <= S_SHIFT;
            busy    <= 1'b1;
            dvalid  <= 1'b1;
            frame   <= 1'b1;
            dout    <= pat_in[PAT_W-1];
          end
        end
        S_SHIFT: begin
          frame <= 1'b0;
          if (!bit_last) begin
            bit_cnt <= bit_cnt + BC_W'(1);
            dout    <= piso_msb;
          end else begin
            bit_cnt <= '0;
            if (PAR_EN) begin
              state <= S_PAR;
              dout  <= ^pat_q;
            end
          end
        end
        S_PAR: begin
          frame <= 1'b0;
        end
        S_GAP: begin
          if (gap_cnt == GAP_W'(1)) begin
            state  <= S_SHIFT;
            frame  <= 1'b1;
            dvalid <= 1'b1;
            dout   <= pat_q[PAT_W-1];
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase

      if (rep_end) begin
        rpt_cnt <= (rpt_cnt == '0) ? '0 : rpt_cnt - CNT_W'(1);
        if (rep_more) begin
          if (gap_q == '0) begin
            state  <= S_SHIFT;
            frame  <= 1'b1;
            dvalid <= 1'b1;
            dout   <= pat_q[PAT_W-1];
          end else begin
            state   <= S_GAP;
            gap_cnt <= gap_q;
            frame   <= 1'b0;
            dvalid  <= 1'b0;
            dout    <= 1'b0;
          end
        end else begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          done   <= 1'b1;
          frame  <= 1'b0;
          dvalid <= 1'b0;
          dout   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sequence_transmitter.sv
// Directed bench for sequence_transmitter; per-cycle traces are packed first-cycle-in-MSB.
module tb_sequence_transmitter;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] pat_in;
  logic [7:0] rpt;
  logic [3:0] gap;
  logic       ready, busy, dout, dvalid, frame, done;

  int errors = 0;
  int checks = 0;

  logic [31:0] c_dout, c_dvalid, c_frame, c_busy, c_done, c_ready;
  int det;

  sequence_transmitter dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .pat_in (pat_in),
    .rpt    (rpt),
    .gap    (gap),
    .ready  (ready),
    .busy   (busy),
    .dout   (dout),
    .dvalid (dvalid),
    .frame  (frame),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic kick(input logic [3:0] p, input logic [7:0] r, input logic [3:0] g);
    @(negedge clk);
    pat_in = p;
    rpt    = r;
    gap    = g;
    start  = 1'b1;
  endtask

  // Samples n cycles after the accept edge; optionally raises start in cycle start_at.
  task automatic capture(input int n, input int start_at, input logic [3:0] pat2);
    logic [3:0] sh;
    sh = '0;
    c_dout = '0; c_dvalid = '0; c_frame = '0; c_busy = '0; c_done = '0; c_ready = '0;
    det = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      c_dout   = {c_dout[30:0], dout};
      c_dvalid = {c_dvalid[30:0], dvalid};
      c_frame  = {c_frame[30:0], frame};
      c_busy   = {c_busy[30:0], busy};
      c_done   = {c_done[30:0], done};
      c_ready  = {c_ready[30:0], ready};
      if (dvalid) begin
        sh = {sh[2:0], dout};
        if (sh == 4'b1001) det++;
      end
      if (i == start_at) begin
        start  = 1'b1;
        pat_in = pat2;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0; pat_in = '0; rpt = '0; gap = '0;
    #1;
    checks++; if ({dout, dvalid, busy, done, frame} !== 5'b0) begin errors++;
      $display("FAIL reset_outs got=%b want=00000", {dout, dvalid, busy, done, frame}); end
    checks++; if (ready !== 1'b1) begin errors++;
      $display("FAIL reset_ready got=%b want=1", ready); end
    repeat (2) @(negedge clk);
    checks++; if ({dout, dvalid, busy, done, frame, ready} !== 6'b000001) begin errors++;
      $display("FAIL reset_held got=%b want=000001", {dout, dvalid, busy, done, frame, ready}); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({busy, done, ready} !== 3'b001) begin errors++;
      $display("FAIL reset_release got=%b want=001", {busy, done, ready}); end
  endtask

  task automatic test_single();
    kick(4'b1001, 8'd1, 4'd0);
    capture(6, 0, 4'b0000);
    checks++; if (c_dout[5:0] !== 6'b100100) begin errors++;
      $display("FAIL single_dout got=%b want=100100", c_dout[5:0]); end
    checks++; if (c_dvalid[5:0] !== 6'b111100) begin errors++;
      $display("FAIL single_dvalid got=%b want=111100", c_dvalid[5:0]); end
    checks++; if (c_frame[5:0] !== 6'b100000) begin errors++;
      $display("FAIL single_frame got=%b want=100000", c_frame[5:0]); end
    checks++; if (c_busy[5:0] !== 6'b111100) begin errors++;
      $display("FAIL single_busy got=%b want=111100", c_busy[5:0]); end
    checks++; if (c_done[5:0] !== 6'b000010) begin errors++;
      $display("FAIL single_done got=%b want=000010", c_done[5:0]); end
    checks++; if (c_ready[5:0] !== 6'b000011) begin errors++;
      $display("FAIL single_ready got=%b want=000011", c_ready[5:0]); end
    checks++; if (det !== 1) begin errors++;
      $display("FAIL single_detect got=%0d want=1", det); end
  endtask

  task automatic test_repeat();
    kick(4'b1001, 8'd3, 4'd0);
    capture(14, 0, 4'b0000);
    checks++; if (c_dout[13:0] !== 14'b10011001100100) begin errors++;
      $display("FAIL rpt3_dout got=%b want=10011001100100", c_dout[13:0]); end
    checks++; if (c_dvalid[13:0] !== 14'b11111111111100) begin errors++;
      $display("FAIL rpt3_dvalid got=%b want=11111111111100", c_dvalid[13:0]); end
    checks++; if (c_frame[13:0] !== 14'b10001000100000) begin errors++;
      $display("FAIL rpt3_frame got=%b want=10001000100000", c_frame[13:0]); end
    checks++; if (c_busy[13:0] !== 14'b11111111111100) begin errors++;
      $display("FAIL rpt3_busy got=%b want=11111111111100", c_busy[13:0]); end
    checks++; if (c_done[13:0] !== 14'b00000000000010) begin errors++;
      $display("FAIL rpt3_done got=%b want=00000000000010", c_done[13:0]); end
    checks++; if (det !== 3) begin errors++;
      $display("FAIL rpt3_detect got=%0d want=3", det); end

    kick(4'b1001, 8'd0, 4'd0);
    capture(6, 0, 4'b0000);
    checks++; if (c_dout[5:0] !== 6'b100100) begin errors++;
      $display("FAIL rpt0_dout got=%b want=100100", c_dout[5:0]); end
    checks++; if (c_done[5:0] !== 6'b000010) begin errors++;
      $display("FAIL rpt0_done got=%b want=000010", c_done[5:0]); end
  endtask

  task automatic test_gap();
    kick(4'b1001, 8'd2, 4'd3);
    capture(13, 6, 4'b0110);
    checks++; if (c_dout[12:0] !== 13'b1001000100100) begin errors++;
      $display("FAIL gap_dout got=%b want=1001000100100", c_dout[12:0]); end
    checks++; if (c_dvalid[12:0] !== 13'b1111000111100) begin errors++;
      $display("FAIL gap_dvalid got=%b want=1111000111100", c_dvalid[12:0]); end
    checks++; if (c_frame[12:0] !== 13'b1000000100000) begin errors++;
      $display("FAIL gap_frame got=%b want=1000000100000", c_frame[12:0]); end
    checks++; if (c_busy[12:0] !== 13'b1111111111100) begin errors++;
      $display("FAIL gap_busy got=%b want=1111111111100", c_busy[12:0]); end
    checks++; if (c_done[12:0] !== 13'b0000000000010) begin errors++;
      $display("FAIL gap_done got=%b want=0000000000010", c_done[12:0]); end
    checks++; if (det !== 2) begin errors++;
      $display("FAIL gap_detect got=%0d want=2", det); end
  endtask

  task automatic test_back_to_back();
    kick(4'b1001, 8'd1, 4'd0);
    capture(11, 5, 4'b0110);
    checks++; if (c_dout[10:0] !== 11'b10010011000) begin errors++;
      $display("FAIL b2b_dout got=%b want=10010011000", c_dout[10:0]); end
    checks++; if (c_frame[10:0] !== 11'b10000100000) begin errors++;
      $display("FAIL b2b_frame got=%b want=10000100000", c_frame[10:0]); end
    checks++; if (c_done[10:0] !== 11'b00001000010) begin errors++;
      $display("FAIL b2b_done got=%b want=00001000010", c_done[10:0]); end
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    kick(4'b1001, 8'd1, 4'd0);
    capture(2, 0, 4'b0000);
    checks++; if (c_dout[1:0] !== 2'b10) begin errors++;
      $display("FAIL mid_pre_dout got=%b want=10", c_dout[1:0]); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({dout, dvalid, busy, done, frame, ready} !== 6'b000001) begin errors++;
      $display("FAIL mid_async got=%b want=000001", {dout, dvalid, busy, done, frame, ready}); end
    @(negedge clk);
    rst = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++;
      $display("FAIL mid_no_resume got=%b want=0", saw_done); end
    kick(4'b0110, 8'd1, 4'd0);
    capture(6, 0, 4'b0000);
    checks++; if (c_dout[5:0] !== 6'b011000) begin errors++;
      $display("FAIL mid_next_dout got=%b want=011000", c_dout[5:0]); end
    checks++; if (c_dvalid[5:0] !== 6'b111100) begin errors++;
      $display("FAIL mid_next_dvalid got=%b want=111100", c_dvalid[5:0]); end
    checks++; if (c_done[5:0] !== 6'b000010) begin errors++;
      $display("FAIL mid_next_done got=%b want=000010", c_done[5:0]); end
  endtask

  task automatic test_parity();
    kick(4'b1001, 8'd1, 4'd0);
    capture(7, 0, 4'b0000);
    checks++; if (c_dout[6:0] !== 7'b1001000) begin errors++;
      $display("FAIL par1001_dout got=%b want=1001000", c_dout[6:0]); end
    checks++; if (c_dvalid[6:0] !== 7'b1111100) begin errors++;
      $display("FAIL par1001_dvalid got=%b want=1111100", c_dvalid[6:0]); end
    checks++; if (c_frame[6:0] !== 7'b1000000) begin errors++;
      $display("FAIL par1001_frame got=%b want=1000000", c_frame[6:0]); end
    checks++; if (c_done[6:0] !== 7'b0000010) begin errors++;
      $display("FAIL par1001_done got=%b want=0000010", c_done[6:0]); end
    kick(4'b1011, 8'd1, 4'd0);
    capture(7, 0, 4'b0000);
    checks++; if (c_dout[6:0] !== 7'b1011100) begin errors++;
      $display("FAIL par1011_dout got=%b want=1011100", c_dout[6:0]); end
    checks++; if (c_done[6:0] !== 7'b0000010) begin errors++;
      $display("FAIL par1011_done got=%b want=0000010", c_done[6:0]); end
  endtask

  initial begin
    test_reset();
`ifdef SEQ_TX_PARITY_EN
    test_parity();
`else
    test_single();
    test_repeat();
    test_gap();
    test_back_to_back();
    test_reset_mid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
